// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP-style bus sequencer: opcodes, one-hot T-states
// and the 12-bit control word.
package sap_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  localparam int unsigned T_COUNT = 6;

  localparam logic [T_COUNT-1:0] T1 = 6'b000001;
  localparam logic [T_COUNT-1:0] T2 = 6'b000010;
  localparam logic [T_COUNT-1:0] T3 = 6'b000100;
  localparam logic [T_COUNT-1:0] T4 = 6'b001000;
  localparam logic [T_COUNT-1:0] T5 = 6'b010000;
  localparam logic [T_COUNT-1:0] T6 = 6'b100000;

  typedef struct packed {
    logic pc_inc;
    logic pc_oe;
    logic mar_load;
    logic ram_oe;
    logic ir_load;
    logic ir_oe;
    logic acc_load;
    logic acc_oe;
    logic breg_load;
    logic alu_sub;
    logic alu_oe;
    logic out_load;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot ring counter with asynchronous active-low reset to bit 0 and a rotate enable.
module sap_ring_counter #(
  parameter int N = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= N'(1);
    end else if (i_en) begin
      r_q <= {r_q[N-2:0], r_q[N-1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sap_sequencer.sv
// Fetch/execute sequencer: T1..T6 ring plus opcode decode into bus-driver/load controls.
// Optional single-step input enabled by defining SAP_SEQ_SINGLE_STEP_EN.
module sap_sequencer
  import sap_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int NUM_T = 6
) (
  input  logic             CLK,
  input  logic             RESET,
`ifdef SAP_SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             run,
  input  logic [OPC_W-1:0] ir_opcode,
  output logic             pc_inc,
  output logic             pc_oe,
  output logic             mar_load,
  output logic             ram_oe,
  output logic             ir_load,
  output logic             ir_oe,
  output logic             acc_load,
  output logic             acc_oe,
  output logic             breg_load,
  output logic             alu_sub,
  output logic             alu_oe,
  output logic             out_load,
  output logic [NUM_T-1:0] tstate,
  output logic             halted
);

  logic             r_halted;
  logic             w_adv;
  logic [NUM_T-1:0] w_tstate;
  opcode_e          w_op;
  ctrl_word_t       w_dec;
  ctrl_word_t       w_ctrl;

`ifdef SAP_SEQ_SINGLE_STEP_EN
  logic r_step_d;
  logic w_step_pulse;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_step_d <= 1'b0;
    end else begin
      r_step_d <= step;
    end
  end

  // High only in the first cycle after step rises, so a held button yields one advance
  assign w_step_pulse = step & ~r_step_d;
  assign w_adv        = (run | w_step_pulse) & ~r_halted & RESET;
`else
  assign w_adv = run & ~r_halted & RESET;
`endif

  sap_ring_counter #(
    .N (NUM_T)
  ) u_ring (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_en    (w_adv),
    .o_q     (w_tstate)
  );

  assign w_op = opcode_e'(ir_opcode);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_halted <= 1'b0;
    end else if (w_adv && (w_tstate == T4) && (w_op == OP_HLT)) begin
      r_halted <= 1'b1;
    end
  end

  // Opcode only matters from T4 on; fetch states decode identically for every instruction
  always_comb begin
    w_dec = CTRL_NOP;
    case (w_tstate)
      T1: begin
        w_dec.pc_oe    = 1'b1;
        w_dec.mar_load = 1'b1;
      end
      T2: w_dec.pc_inc = 1'b1;
      T3: begin
        w_dec.ram_oe  = 1'b1;
        w_dec.ir_load = 1'b1;
      end
      T4: begin
        case (w_op)
          OP_LDA, OP_ADD, OP_SUB: begin
            w_dec.ir_oe    = 1'b1;
            w_dec.mar_load = 1'b1;
          end
          OP_OUT: begin
            w_dec.acc_oe   = 1'b1;
            w_dec.out_load = 1'b1;
          end
          default: w_dec = CTRL_NOP;
        endcase
      end
      T5: begin
        case (w_op)
          OP_LDA: begin
            w_dec.ram_oe   = 1'b1;
            w_dec.acc_load = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_dec.ram_oe    = 1'b1;
            w_dec.breg_load = 1'b1;
            w_dec.alu_sub   = (w_op == OP_SUB);
          end
          default: w_dec = CTRL_NOP;
        endcase
      end
      T6: begin
        case (w_op)
          OP_ADD, OP_SUB: begin
            w_dec.alu_oe   = 1'b1;
            w_dec.acc_load = 1'b1;
            w_dec.alu_sub  = (w_op == OP_SUB);
          end
          default: w_dec = CTRL_NOP;
        endcase
      end
      default: w_dec = CTRL_NOP;
    endcase
  end

  // Frozen cycles must not repeat a load or increment, so gate the whole word
  assign w_ctrl = w_adv ? w_dec : CTRL_NOP;

  assign pc_inc    = w_ctrl.pc_inc;
  assign pc_oe     = w_ctrl.pc_oe;
  assign mar_load  = w_ctrl.mar_load;
  assign ram_oe    = w_ctrl.ram_oe;
  assign ir_load   = w_ctrl.ir_load;
  assign ir_oe     = w_ctrl.ir_oe;
  assign acc_load  = w_ctrl.acc_load;
  assign acc_oe    = w_ctrl.acc_oe;
  assign breg_load = w_ctrl.breg_load;
  assign alu_sub   = w_ctrl.alu_sub;
  assign alu_oe    = w_ctrl.alu_oe;
  assign out_load  = w_ctrl.out_load;
  assign tstate    = w_tstate;
  assign halted    = r_halted;

endmodule
